pc_redirect_controller: RTL

//   Owns the fetch PC register of the pipelined MIPS core and sequences every PC redirect.

---
 rtl/pc_redirect_controller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_redirect_controller.sv
// Fetch PC register and redirect sequencer: selects PC+4, branch or jump target, drives the IF/ID flush.
// Optional jr/jalr redirect path is compiled in when JR_SUPPORT_EN is defined.
module pc_redirect_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          REDIR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   jump_valid,
    input  logic [31:0]            jump_addr,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_addr,
    input  logic                   halt_req,
`ifdef JR_SUPPORT_EN
    input  logic                   jr_valid,
    input  logic [31:0]            jr_addr,
`endif
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic                   if_id_flush,
    output logic                   fetch_valid,
    output logic [1:0]             ctrl_state,
    output logic [REDIR_CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REDIR  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [31:0]            ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0]            PC_STEP    = 32'd4;
    localparam logic [REDIR_CNT_W-1:0] CNT_ONE    = {{(REDIR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REDIR_CNT_W-1:0] CNT_MAX    = {REDIR_CNT_W{1'b1}};

    state_t                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [REDIR_CNT_W-1:0] cnt_q, cnt_d;

    logic                   redir_req;
    logic [31:0]            redir_target_raw;
    logic [31:0]            redir_target;
    logic [31:0]            pc_inc;

    assign pc_inc = pc_q + PC_STEP;

    // Redirect source selection: a branch always wins; jr (when present) beats a plain jump.
    always_comb begin
        redir_req        = branch_taken | jump_valid;
        redir_target_raw = jump_addr;
`ifdef JR_SUPPORT_EN
        redir_req = redir_req | jr_valid;
        if (jr_valid) begin
            redir_target_raw = jr_addr;
        end
`endif
        if (branch_taken) begin
            redir_target_raw = branch_addr;
        end
        redir_target = redir_target_raw & ALIGN_MASK;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        if_id_flush = 1'b0;
        fetch_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                fetch_valid = 1'b1;
                if (stall) begin
                    // Requesters hold their requests; they are re-evaluated once the stall drops.
                    state_d = ST_RUN;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (redir_req) begin
                    pc_d        = redir_target;
                    if_id_flush = 1'b1;
                    state_d     = ST_REDIR;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end

            ST_REDIR: begin
                // IF/ID holds the flushed bubble, so any request seen now is stale.
                fetch_valid = 1'b1;
                if (!stall) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC & ALIGN_MASK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc             = pc_q;
    assign pc_plus4       = pc_inc;
    assign ctrl_state     = state_q;
    assign redirect_count = cnt_q;

endmodule
